// File: rtl/cpu_inta_sequencer.sv
// rtl/cpu_inta_sequencer.sv - CPU-side two-pulse INTA initiator with vector capture
// Samples PIC INT, drives INTA/LOCK, captures D on the second pulse, hands vector out.
module cpu_inta_sequencer #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  input  logic [7:0] D,
  input  logic       irq_enable,
  input  logic       instr_boundary,
  input  logic       vector_ready,
  output logic       INTA,
  output logic       LOCK,
  output logic       busy,
  output logic       vector_valid,
  output logic [7:0] vector
);

  localparam int MAX_CYC = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] LOW_LAST = CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(INTA_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK1,
    S_GAP,
    S_ACK2,
    S_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   inta_q, inta_d;
  logic                   lock_q, lock_d;
  logic                   busy_q, busy_d;
  logic                   vv_q, vv_d;
  logic [7:0]             vector_q, vector_d;
  logic                   int_s;

  assign int_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = INT;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    inta_d   = inta_q;
    lock_d   = lock_q;
    busy_d   = busy_q;
    vv_d     = vv_q;
    vector_d = vector_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (int_s && irq_enable && instr_boundary) begin
          state_d = S_ACK1;
          inta_d  = 1'b0;
          lock_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      // Timed states ignore INT and the qualifiers: once started, the sequence completes.
      S_ACK1: begin
        if (cnt_q == LOW_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          inta_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_ACK2;
          cnt_d   = '0;
          inta_d  = 1'b0;
        end
      end
      S_ACK2: begin
        if (cnt_q == LOW_LAST) begin
          state_d  = S_HOLD;
          cnt_d    = '0;
          vector_d = D;
          inta_d   = 1'b1;
          lock_d   = 1'b0;
          vv_d     = 1'b1;
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        if (vector_ready) begin
          state_d = S_IDLE;
          vv_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sync_q   <= '0;
      inta_q   <= 1'b1;
      lock_q   <= 1'b0;
      busy_q   <= 1'b0;
      vv_q     <= 1'b0;
      vector_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      inta_q   <= inta_d;
      lock_q   <= lock_d;
      busy_q   <= busy_d;
      vv_q     <= vv_d;
      vector_q <= vector_d;
    end
  end

  assign INTA         = inta_q;
  assign LOCK         = lock_q;
  assign busy         = busy_q;
  assign vector_valid = vv_q;
  assign vector       = vector_q;

endmodule
